axis_pkt_framer: RTL and testbench
==================================

Name: axis_pkt_framer

Overview:
- Converts a free-running sample source (valid/data, no backpressure) into framed AXI4-Stream packets of a programmable length, with TLAST on the final beat.
- Feeds the AXI DMA S2MM channel, so S2MM transfers terminate cleanly.
- Sits in the same IP as the M_AXIS master stage and replaces its fixed counter data source.
- A small FIFO absorbs DMA backpressure. Samples are dropped, and counted, only when the FIFO is full.

Parameters:
- C_M_AXIS_TDATA_WIDTH, 32: sample / TDATA width in bits; must be a multiple of 8.
- C_FIFO_DEPTH, 16: FIFO entries; must be a power of 2, at least 4.
- C_LEN_WIDTH, 16: width of PKT_LEN and OVERFLOW_CNT.

Ports:
- M_AXIS_ACLK  in  1  sole clock; every register is clocked on its rising edge.
- M_AXIS_ARESETN  in  1  reset, synchronous and active-low.
- EN  in  1  level enable for framing (from the AXI-Lite control register).
- PKT_LEN  in  C_LEN_WIDTH  beats per packet; sampled at packet start.
- SRC_VALID  in  1  source sample strobe.
- SRC_DATA  in  C_M_AXIS_TDATA_WIDTH  source sample.
- M_AXIS_TVALID  out  1  stream valid.
- M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  stream data.
- M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  byte strobes.
- M_AXIS_TLAST  out  1  last beat of packet.
- M_AXIS_TREADY  in  1  downstream ready.
- BUSY  out  1  high in STREAM state.
- PKT_DONE  out  1  one-cycle pulse per completed packet.
- OVERFLOW_CNT  out  C_LEN_WIDTH  saturating count of dropped samples.

Behaviour:
Reset (M_AXIS_ARESETN=0 at a clock edge):
- State goes to IDLE and the FIFO empties.
- Beat counter and OVERFLOW_CNT go to 0.
- TVALID, TLAST, BUSY and PKT_DONE go to 0.
- Reset mid-packet abandons the packet with no TLAST; the DMA side is reset with it.

TSTRB: constant all-ones.

State machine, IDLE and STREAM:
- IDLE -> STREAM when EN=1 and PKT_LEN!=0. On that edge, len_q<=PKT_LEN and beat<=0.
- PKT_LEN=0 keeps the block in IDLE.
- In STREAM, each handshake (TVALID&TREADY) increments beat.
- TLAST = (beat==len_q-1) & TVALID.
- On the TLAST handshake:
  - if EN=1: stay in STREAM, reload len_q<=PKT_LEN, beat<=0. If the new PKT_LEN=0, go to IDLE instead.
  - if EN=0: go to IDLE.
- EN falling mid-packet does not truncate the packet; the current packet completes.
- Entering IDLE flushes the FIFO, so residual samples never leak into the next packet.

FIFO write rules:
- Write when state==STREAM, SRC_VALID=1 and the FIFO is not full.
- Full blocks the write even when a read occurs in the same cycle.
- A sample presented while full in STREAM is dropped and OVERFLOW_CNT increments, saturating at all-ones.
- Samples arriving in IDLE are ignored and not counted.

FIFO read side:
- First-word fall-through.
- TVALID = (state==STREAM) & !empty, and TDATA = FIFO head.
- A sample written at edge N appears on TDATA/TVALID after edge N and is presentable in cycle N+1; there is no extra bubble.
- Read pointer advances only on handshake.
- TVALID, TDATA and TLAST stay stable while TVALID=1 and TREADY=0, as AXI-Stream requires.
- Simultaneous read and write when neither full nor empty keeps the occupancy unchanged.

PKT_DONE: registered, high for exactly the one cycle after each TLAST handshake.

BUSY: equals (state==STREAM).

Widths and pointers:
- Beat counter and len_q are C_LEN_WIDTH bits.
- FIFO pointers are log2(C_FIFO_DEPTH)+1 bits, with an MSB wrap bit distinguishing full from empty.
- Pointers wrap modulo 2*C_FIFO_DEPTH.

Decomposition:
- Package axis_pkt_pkg holds:
  - state enum {S_IDLE, S_STREAM};
  - a localparam function clog2;
  - the default-width constants.
- Sub-module axis_pkt_fifo: synchronous first-word fall-through FIFO with ports wr_en, wr_data, full, rd_en, rd_data, empty, flush.
- The framer FSM, beat counter and overflow counter live in the top module.

Test Plan:
1. EN=1, PKT_LEN=4, SRC_VALID every cycle with data 1,2,3..., TREADY=1 -> beats 1,2,3,4 with TLAST on 4, then 5..8 with TLAST on 8; PKT_DONE pulses one cycle after each last beat; OVERFLOW_CNT=0.
2. PKT_LEN=8, C_FIFO_DEPTH=16, TREADY=0 for 20 cycles with continuous SRC_VALID -> FIFO holds 16, OVERFLOW_CNT=4; TVALID/TDATA held at sample 1 throughout; releasing TREADY delivers 1..16 in order, TLAST on beats 8 and 16.
3. EN dropped after beat 2 of a PKT_LEN=5 packet -> beats 3..5 still delivered with TLAST on 5; then IDLE, BUSY=0, FIFO flushed; re-enabling starts a fresh packet with beat count 0.
4. PKT_LEN=0 with EN=1 -> stays IDLE, TVALID=0, BUSY=0; changing PKT_LEN from 3 to 6 mid-packet -> current packet still 3 beats, next packet 6.
5. Reset asserted mid-packet (beat 2 of 4) -> at the next edge TVALID=0, BUSY=0, OVERFLOW_CNT=0; after release with EN=1, the first packet begins at beat 0 with new data only.
6. Random TREADY (50%) with intermittent SRC_VALID, PKT_LEN=7, 1000 samples -> scoreboard shows in-order data with no duplicates, TLAST on every 7th beat, and delivered + dropped = samples offered in STREAM.

Source files
------------

// File: rtl/axis_pkt_pkg.sv
// Shared types and constants for the AXI-Stream packet framer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_pkt_pkg;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_STREAM = 1'b1
    } state_t;

    localparam int DEF_TDATA_WIDTH = 32;
    localparam int DEF_FIFO_DEPTH  = 16;
    localparam int DEF_LEN_WIDTH   = 16;

    // Ceiling log2, usable in parameter and localparam expressions.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/axis_pkt_fifo.sv
// Synchronous first-word fall-through FIFO with a flush that empties it in one edge.
// Latency: a word written at edge N is on rd_data with empty=0 during cycle N+1.
// Backpressure: writes are ignored while full (even with a same-cycle read); reads are ignored while empty.
module axis_pkt_fifo
    import axis_pkt_pkg::*;
#(
    parameter int WIDTH = DEF_TDATA_WIDTH,
    parameter int DEPTH = DEF_FIFO_DEPTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int AW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // The extra MSB on each pointer tells a full ring from an empty one.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_wr   = wr_en & ~full;
    assign do_rd   = rd_en & ~empty;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // Pointer update; flush and reset both collapse the ring to empty.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

    // Storage needs no reset: pointers alone decide what is valid.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/axis_pkt_framer.sv
// Frames a free-running sample stream into AXI-Stream packets of PKT_LEN beats with TLAST.
// Latency: a sample accepted at edge N is presented on M_AXIS in cycle N+1 (FWFT, no bubble).
// Backpressure: TREADY low stalls the FIFO; samples arriving while it is full are dropped and counted.
module axis_pkt_framer
    import axis_pkt_pkg::*;
#(
    parameter int C_M_AXIS_TDATA_WIDTH = DEF_TDATA_WIDTH,
    parameter int C_FIFO_DEPTH         = DEF_FIFO_DEPTH,
    parameter int C_LEN_WIDTH          = DEF_LEN_WIDTH
) (
    input  logic                              M_AXIS_ACLK,
    input  logic                              M_AXIS_ARESETN,
    input  logic                              EN,
    input  logic [C_LEN_WIDTH-1:0]            PKT_LEN,
    input  logic                              SRC_VALID,
    input  logic [C_M_AXIS_TDATA_WIDTH-1:0]   SRC_DATA,
    output logic                              M_AXIS_TVALID,
    output logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
    output logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
    output logic                              M_AXIS_TLAST,
    input  logic                              M_AXIS_TREADY,
    output logic                              BUSY,
    output logic                              PKT_DONE,
    output logic [C_LEN_WIDTH-1:0]            OVERFLOW_CNT
);

    state_t                    state;
    logic [C_LEN_WIDTH-1:0]    len_q;
    logic [C_LEN_WIDTH-1:0]    beat;
    logic [C_LEN_WIDTH-1:0]    ovf_cnt;
    logic                      pkt_done_q;

    logic                      streaming;
    logic                      fifo_wr;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      fifo_flush;
    logic [C_M_AXIS_TDATA_WIDTH-1:0] fifo_head;
    logic                      hs;
    logic                      last_hs;
    logic                      next_pkt_ok;

    assign streaming   = (state == S_STREAM);
    assign fifo_wr     = streaming & SRC_VALID & ~fifo_full;
    // Holding the FIFO flushed while idle guarantees every packet starts from fresh samples.
    assign fifo_flush  = ~streaming;
    assign next_pkt_ok = EN && (PKT_LEN != '0);

    assign M_AXIS_TVALID = streaming & ~fifo_empty;
    assign M_AXIS_TDATA  = fifo_head;
    assign M_AXIS_TSTRB  = '1;
    assign M_AXIS_TLAST  = M_AXIS_TVALID & (beat == len_q - C_LEN_WIDTH'(1));
    assign hs            = M_AXIS_TVALID & M_AXIS_TREADY;
    assign last_hs       = hs & M_AXIS_TLAST;

    assign BUSY         = streaming;
    assign PKT_DONE     = pkt_done_q;
    assign OVERFLOW_CNT = ovf_cnt;

    axis_pkt_fifo #(
        .WIDTH (C_M_AXIS_TDATA_WIDTH),
        .DEPTH (C_FIFO_DEPTH)
    ) u_fifo (
        .clk     (M_AXIS_ACLK),
        .rst_n   (M_AXIS_ARESETN),
        .flush   (fifo_flush),
        .wr_en   (fifo_wr),
        .wr_data (SRC_DATA),
        .full    (fifo_full),
        .rd_en   (hs),
        .rd_data (fifo_head),
        .empty   (fifo_empty)
    );

    // Framer FSM: packet length is latched at packet start, so PKT_LEN/EN changes act on the next packet.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            state      <= S_IDLE;
            len_q      <= '0;
            beat       <= '0;
            pkt_done_q <= 1'b0;
        end else begin
            pkt_done_q <= last_hs;
            case (state)
                S_IDLE: begin
                    if (next_pkt_ok) begin
                        state <= S_STREAM;
                        len_q <= PKT_LEN;
                        beat  <= '0;
                    end
                end
                S_STREAM: begin
                    if (last_hs) begin
                        beat <= '0;
                        if (next_pkt_ok) begin
                            len_q <= PKT_LEN;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (hs) begin
                        beat <= beat + C_LEN_WIDTH'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Saturating count of samples lost to a full FIFO while streaming.
    always_ff @(posedge M_AXIS_ACLK) begin
        if (!M_AXIS_ARESETN) begin
            ovf_cnt <= '0;
        end else if (streaming && SRC_VALID && fifo_full && (ovf_cnt != '1)) begin
            ovf_cnt <= ovf_cnt + C_LEN_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Scoreboard bench for axis_pkt_framer: stimulus pushes expected beats, a negedge monitor pops them.
// Latency: n/a.
// Backpressure: TREADY is driven by the bench (held, released, or random).
module tb_axis_pkt_framer;

    localparam int W  = 32;
    localparam int LW = 16;
    localparam int D  = 16;

    typedef struct {
        logic [W-1:0] data;
        logic         last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic          src_valid = 1'b0;
    logic [W-1:0]  src_data = '0;
    logic          tvalid;
    logic [W-1:0]  tdata;
    logic [W/8-1:0] tstrb;
    logic          tlast;
    logic          tready = 1'b0;
    logic          busy;
    logic          pkt_done;
    logic [LW-1:0] ovf;

    int n_vec = 0;
    int n_err = 0;
    int n_deliv = 0;

    beat_t exp_q[$];
    beat_t mon_e;
    logic  prev_done_exp = 1'b0;
    logic  stall_prev = 1'b0;
    logic [W-1:0] prev_data = '0;
    logic  prev_last = 1'b0;

    axis_pkt_framer #(
        .C_M_AXIS_TDATA_WIDTH (W),
        .C_FIFO_DEPTH         (D),
        .C_LEN_WIDTH          (LW)
    ) dut (
        .M_AXIS_ACLK    (clk),
        .M_AXIS_ARESETN (rst_n),
        .EN             (en),
        .PKT_LEN        (pkt_len),
        .SRC_VALID      (src_valid),
        .SRC_DATA       (src_data),
        .M_AXIS_TVALID  (tvalid),
        .M_AXIS_TDATA   (tdata),
        .M_AXIS_TSTRB   (tstrb),
        .M_AXIS_TLAST   (tlast),
        .M_AXIS_TREADY  (tready),
        .BUSY           (busy),
        .PKT_DONE       (pkt_done),
        .OVERFLOW_CNT   (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: scoreboard pop on handshake, PKT_DONE timing, and AXI stability under stall.
    always @(negedge clk) begin
        if (rst_n && tvalid && tready) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_beat: got data 0x%0h last %0b, expected no beat", tdata, tlast);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat_data", tdata, mon_e.data);
                check("beat_last", tlast, mon_e.last);
                n_deliv++;
            end
        end
        if (pkt_done || prev_done_exp) begin
            check("pkt_done", pkt_done, prev_done_exp);
        end
        if (stall_prev) begin
            check("stall_tvalid", tvalid, 1'b1);
            check("stall_tdata", tdata, prev_data);
            check("stall_tlast", tlast, prev_last);
        end
        prev_done_exp = rst_n && tvalid && tready && tlast;
        stall_prev    = rst_n && tvalid && !tready;
        prev_data     = tdata;
        prev_last     = tlast;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [W-1:0] d, input logic last);
        beat_t b;
        b.data = d;
        b.last = last;
        exp_q.push_back(b);
    endtask

    task automatic feed(input logic [W-1:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            src_valid = 1'b1;
            src_data  = start + W'(i);
            tick();
        end
        src_valid = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            tick();
        end
        tick();
        check(name, exp_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        en        = 1'b0;
        src_valid = 1'b0;
        tready    = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt, acc, drops, offered, d0;
        logic v, r, hs_m, wr_m;

        // Reset state
        do_reset();
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_pkt_done", pkt_done, 1'b0);
        check("rst_ovf", ovf, 0);
        check("tstrb", tstrb, 4'hF);
        rst_n = 1'b1;

        // 1: two back-to-back 4-beat packets, no backpressure
        en = 1'b1; pkt_len = 4; tready = 1'b1;
        tick();
        for (int i = 1; i <= 8; i++) push(W'(i), (i % 4) == 0);
        feed(1, 8);
        @(negedge clk);
        check("t1_busy", busy, 1'b1);
        drain("t1_drain", 30);
        check("t1_ovf", ovf, 0);

        // 2: stalled DMA fills FIFO, four samples dropped, then release
        do_reset();
        en = 1'b1; pkt_len = 8; tready = 1'b0;
        tick();
        for (int i = 1; i <= 16; i++) push(W'(i), (i % 8) == 0);
        feed(1, 20);
        @(negedge clk);
        check("t2_tvalid_held", tvalid, 1'b1);
        check("t2_tdata_held", tdata, 1);
        check("t2_tlast_held", tlast, 1'b0);
        check("t2_ovf", ovf, 4);
        tready = 1'b1;
        drain("t2_drain", 40);

        // 3: EN falls mid-packet; packet completes, residual sample 36 is flushed
        do_reset();
        en = 1'b1; pkt_len = 5; tready = 1'b1;
        tick();
        for (int i = 31; i <= 35; i++) push(W'(i), i == 35);
        feed(31, 2);
        en = 1'b0;
        feed(33, 4);
        tick(); tick(); tick();
        @(negedge clk);
        check("t3_idle_busy", busy, 1'b0);
        check("t3_idle_tvalid", tvalid, 1'b0);
        feed(99, 2);
        en = 1'b1;
        tick();
        for (int i = 41; i <= 45; i++) push(W'(i), i == 45);
        feed(41, 5);
        drain("t3_drain", 30);
        check("t3_ovf", ovf, 0);

        // 4: PKT_LEN=0 holds IDLE; PKT_LEN change mid-packet applies to the next packet
        do_reset();
        en = 1'b1; pkt_len = 0; tready = 1'b1;
        feed(32'h77, 4);
        @(negedge clk);
        check("t4_len0_busy", busy, 1'b0);
        check("t4_len0_tvalid", tvalid, 1'b0);
        pkt_len = 3;
        tick();
        for (int i = 51; i <= 59; i++) push(W'(i), (i == 53) || (i == 59));
        feed(51, 1);
        pkt_len = 6;
        feed(52, 8);
        drain("t4_drain", 30);

        // 5: reset while beat 2 of 4 is stalled with overflow pending
        do_reset();
        en = 1'b1; pkt_len = 4; tready = 1'b1;
        tick();
        push(61, 1'b0);
        push(62, 1'b0);
        feed(61, 3);
        tready = 1'b0;
        feed(64, 17);
        @(negedge clk);
        check("t5_pre_ovf", ovf, 2);
        check("t5_pre_tdata", tdata, 63);
        rst_n = 1'b0;
        tick();
        @(negedge clk);
        check("t5_rst_tvalid", tvalid, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        check("t5_rst_ovf", ovf, 0);
        rst_n = 1'b1; en = 1'b1; pkt_len = 4; tready = 1'b1;
        tick();
        for (int i = 81; i <= 84; i++) push(W'(i), i == 84);
        feed(81, 4);
        drain("t5_drain", 30);

        // 6: random TREADY, intermittent samples, occupancy model decides drops
        do_reset();
        en = 1'b1; pkt_len = 7; tready = 1'b0;
        tick();
        cnt = 0; acc = 0; drops = 0; offered = 0; d0 = n_deliv;
        while (offered < 1000) begin
            v = ($urandom_range(0, 9) < 6);
            r = ($urandom_range(0, 1) == 1);
            src_valid = v;
            src_data  = 32'h1000 + W'(offered);
            tready    = r;
            hs_m = (cnt > 0) && r;
            wr_m = v && (cnt < D);
            if (wr_m) begin
                push(32'h1000 + W'(offered), (acc % 7) == 6);
                acc++;
            end else if (v) begin
                drops++;
            end
            cnt = cnt + (wr_m ? 1 : 0) - (hs_m ? 1 : 0);
            if (v) offered++;
            tick();
        end
        src_valid = 1'b0;
        tready = 1'b1;
        drain("t6_drain", 100);
        check("t6_ovf", ovf, drops);
        check("t6_conservation", (n_deliv - d0) + int'(ovf), 1000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
